// File: rtl/muldiv_pkg.sv
// muldiv_pkg: funct3 encodings, FSM state type and operand-class helpers
// shared by the muldiv_sequencer slice.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic is_div(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

    function automatic logic op1_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic op2_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// muldiv_iter_step: one combinational iteration on {acc, q}; shift-add for
// multiply (q holds the multiplier) or restore-subtract for divide (q holds the dividend).
module muldiv_iter_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] q_i,
    input  logic [XLEN-1:0] opnd_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] q_o
);

    logic [XLEN:0] add_sum;
    logic [XLEN:0] rem_sh;
    logic          ge;

    always_comb begin
        add_sum = {1'b0, acc_i} + (q_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh  = {acc_i, q_i[XLEN-1]};
        ge      = rem_sh >= {1'b0, opnd_i};
        if (is_div_i) begin
            // partial remainder stays below the divisor, so the low XLEN bits suffice
            acc_o = ge ? (rem_sh[XLEN-1:0] - opnd_i) : rem_sh[XLEN-1:0];
            q_o   = {q_i[XLEN-2:0], ge};
        end else begin
            acc_o = add_sum[XLEN:1];
            q_o   = {add_sum[0], q_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide with busy/done handshake.
// Define MULDIV_FAST_MUL_EN for single-cycle combinational multiplies.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   acc_q, q_q, opnd_q, result_q;
    logic              neg_res_q, neg_rem_q, busy_q, done_q;

    logic              op1_neg, op2_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   op1_mag, op2_mag, spec_res;
    logic [XLEN-1:0]   step_acc, step_q;
    logic [2*XLEN-1:0] prod_raw, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;

    assign op1_neg  = op1_signed(funct3) && op1[XLEN-1];
    assign op2_neg  = op2_signed(funct3) && op2[XLEN-1];
    assign op1_mag  = op1_neg ? -op1 : op1;
    assign op2_mag  = op2_neg ? -op2 : op2;
    assign div_zero = is_div(funct3) && (op2 == '0);
    assign div_ovf  = is_div(funct3) && op1_signed(funct3) &&
                      (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
    // overflow DIV result equals op1 itself, which lets both cases share one mux
    assign spec_res = funct3[1] ? (div_zero ? op1 : '0) : (div_zero ? '1 : op1);

    muldiv_iter_step #(.XLEN(XLEN)) u_step (
        .is_div_i (is_div(f3_q)),
        .acc_i    (acc_q),
        .q_i      (q_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc),
        .q_o      (step_q)
    );

    always_comb begin
        prod_raw = {step_acc, step_q};
        prod_fix = neg_res_q ? -prod_raw : prod_raw;
        quo_fix  = neg_res_q ? -step_q : step_q;
        rem_fix  = neg_rem_q ? -step_acc : step_acc;
        if (is_div(f3_q))
            fin_res = f3_q[1] ? rem_fix : quo_fix;
        else
            fin_res = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod, fast_fix;
    logic [XLEN-1:0]   fast_res;

    always_comb begin
        fast_prod = {{XLEN{1'b0}}, op1_mag} * {{XLEN{1'b0}}, op2_mag};
        fast_fix  = (op1_neg ^ op2_neg) ? -fast_prod : fast_prod;
        fast_res  = (funct3 == F3_MUL) ? fast_fix[XLEN-1:0] : fast_fix[2*XLEN-1:XLEN];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            f3_q      <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start && !flush) begin
                        f3_q      <= funct3;
                        neg_res_q <= op1_neg ^ op2_neg;
                        neg_rem_q <= op1_neg;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        q_q       <= is_div(funct3) ? op1_mag : op2_mag;
                        opnd_q    <= is_div(funct3) ? op2_mag : op1_mag;
                        if (div_zero || div_ovf) begin
                            result_q <= spec_res;
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!is_div(funct3)) begin
                            result_q <= fast_res;
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end
`endif
                        else begin
                            busy_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        acc_q <= step_acc;
                        q_q   <= step_q;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(XLEN-1)) begin
                            result_q <= fin_res;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vector table, corner-case sequences and a
// randomized run against an arithmetic reference model.
module tb_muldiv_sequencer;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, flush, busy, done;
    logic [2:0]  funct3;
    logic [31:0] op1, op2, result;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op1    (op1),
        .op2    (op2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa, sb, ub;
        logic [63:0]        p;
        logic signed [31:0] as, bs;
        logic [31:0]        r;
        bit                 ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ub  = {32'b0, b};
        as  = a;
        bs  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        case (f3)
            MUL:    begin p = {32'b0, a} * {32'b0, b}; r = p[31:0];  end
            MULH:   begin p = sa * sb;                 r = p[63:32]; end
            MULHSU: begin p = sa * ub;                 r = p[63:32]; end
            MULHU:  begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            DIV:    if (b == 0) r = '1; else if (ovf) r = 32'h8000_0000; else r = as / bs;
            DIVU:   if (b == 0) r = '1; else r = a / b;
            REM:    if (b == 0) r = a;  else if (ovf) r = '0; else r = as % bs;
            default: if (b == 0) r = a; else r = a % b;
        endcase
        return r;
    endfunction

    function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = f3[2] && ((b == 0) ||
                  (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        return (special || (FAST && !f3[2])) ? 1 : 33;
    endfunction

    // Issue one op from a post-edge point and check result, latency, busy span and pulse width.
    task automatic do_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat_exp);
        int k, bc;
        bit got;
        logic [31:0] r;
        funct3 = f3; op1 = a; op2 = b; start = 1'b1;
        tick();
        start = 1'b0;
        funct3 = 3'($urandom); op1 = $urandom; op2 = $urandom;
        k = 1; bc = 0; got = 1'b0; r = '0;
        while (!got && k < 100) begin
            if (busy) bc++;
            if (done) begin
                got = 1'b1;
                r = result;
            end else begin
                tick();
                k++;
            end
        end
        chk({nm, "/done_seen"}, 32'(got), 32'd1);
        chk({nm, "/result"}, r, exp);
        chk({nm, "/latency"}, 32'(k), 32'(lat_exp));
        chk({nm, "/busy_cycles"}, 32'(bc), (lat_exp == 33) ? 32'd32 : 32'd0);
        tick();
        chk({nm, "/done_pulse"}, 32'(done), 32'd0);
        chk({nm, "/result_hold"}, result, exp);
    endtask

    task automatic count_done(input int n, output int cnt, output logic [31:0] last);
        cnt = 0;
        last = result;
        for (int i = 0; i < n; i++) begin
            if (done) begin
                cnt++;
                last = result;
            end
            tick();
        end
    endtask

    initial begin
        int cnt;
        logic [31:0] last, a, b;
        logic [2:0]  f3;
        logic [31:0] corner[5];

        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op1 = '0; op2 = '0;
        vecs[0]  = '{MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
        vecs[4]  = '{DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{DIVU,   32'd100,        32'd7,         32'd14};
        vecs[7]  = '{REMU,   32'd100,        32'd7,         32'd2};
        vecs[8]  = '{DIVU,   32'h1234,       32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{REM,    32'h1234,       32'd0,         32'h1234};
        vecs[10] = '{DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        vecs[12] = '{MUL,    32'd6,          32'd7,         32'd42};
        corner = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset/busy", 32'(busy), 32'd0);
        chk("reset/done", 32'(done), 32'd0);
        chk("reset/result", result, 32'd0);

        for (int i = 0; i < 13; i++)
            do_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp,
                  lat_of(vecs[i].f3, vecs[i].a, vecs[i].b));

        // flush at RUN cycle 10: no done, old result kept, then a fresh op works
        do_op("pre_flush", DIVU, 32'd100, 32'd7, 32'd14, 33);
        funct3 = DIVU; op1 = 32'hFFFF; op2 = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush/busy", 32'(busy), 32'd0);
        chk("flush/done", 32'(done), 32'd0);
        count_done(40, cnt, last);
        chk("flush/no_done", 32'(cnt), 32'd0);
        chk("flush/result_kept", result, 32'd14);
        do_op("post_flush", DIVU, 32'd9, 32'd3, 32'd3, 33);

        // start and flush together in IDLE: start ignored
        funct3 = DIVU; op1 = 32'd9; op2 = 32'd0; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("idle_flush/busy", 32'(busy), 32'd0);
        chk("idle_flush/done", 32'(done), 32'd0);

        // start during RUN is not queued
        funct3 = DIVU; op1 = 32'd1000; op2 = 32'd10; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        funct3 = MUL; op1 = 32'd5; op2 = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        count_done(60, cnt, last);
        chk("run_start/pulses", 32'(cnt), 32'd1);
        chk("run_start/result", last, 32'd100);

        // reset at RUN cycle 5
        funct3 = DIVU; op1 = 32'd1000; op2 = 32'd10; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst/busy", 32'(busy), 32'd0);
        chk("midrst/done", 32'(done), 32'd0);
        chk("midrst/result", result, 32'd0);
        count_done(40, cnt, last);
        chk("midrst/no_done", 32'(cnt), 32'd0);
        do_op("post_rst", DIVU, 32'd100, 32'd7, 32'd14, 33);

        for (int i = 0; i < 150; i++) begin
            f3 = 3'($urandom);
            a = ($urandom_range(3) == 0) ? corner[$urandom_range(4)] : $urandom;
            b = ($urandom_range(3) == 0) ? corner[$urandom_range(4)] : $urandom;
            if ($urandom_range(7) == 0) b = $urandom_range(15);
            do_op($sformatf("rnd%0d_f%0d", i, f3), f3, a, b, ref_res(f3, a, b), lat_of(f3, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
